// File: rtl/reg_writeback_if.sv
// reg_writeback_if: bundles the write-back block's ALU/load/read-address inputs and its
// write, hazard and occupancy outputs.
//   master : upstream side (drives ALU results, loads, read addresses)
//   slave  : reg_writeback itself
// Optional macro WB_BYPASS_EN adds the byp1_*/byp2_* bypass signals.
interface reg_writeback_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_dest;
    logic [DW-1:0] alu_data;
    logic          alu_wr0;
    logic [DW-1:0] alu_r0data;
    logic          mem_valid;
    logic [AW-1:0] mem_dest;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] add1;
    logic [AW-1:0] add2;
    logic          hazard1;
    logic          hazard2;
    logic [AW-1:0] wadd;
    logic [DW-1:0] wdata;
    logic          regwrite;
    logic [DW-1:0] wr0;
    logic          r0write;
    logic [CW-1:0] count;
`ifdef WB_BYPASS_EN
    logic          byp1_valid;
    logic [DW-1:0] byp1_data;
    logic          byp2_valid;
    logic [DW-1:0] byp2_data;
`endif

    modport master (
        output alu_valid, alu_dest, alu_data, alu_wr0, alu_r0data,
        output mem_valid, mem_dest, mem_data, add1, add2,
        input  alu_ready, hazard1, hazard2, wadd, wdata, regwrite, wr0, r0write, count
`ifdef WB_BYPASS_EN
        , input byp1_valid, byp1_data, byp2_valid, byp2_data
`endif
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data, alu_wr0, alu_r0data,
        input  mem_valid, mem_dest, mem_data, add1, add2,
        output alu_ready, hazard1, hazard2, wadd, wdata, regwrite, wr0, r0write, count
`ifdef WB_BYPASS_EN
        , output byp1_valid, byp1_data, byp2_valid, byp2_data
`endif
    );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: write-side companion to the register file. Buffers ALU results in a
// DEPTH-entry FIFO, arbitrates loads (priority) against the FIFO head, and issues one
// registered general write plus an optional R0 write per cycle. Reports read-after-write
// hazards for the two operand read addresses.
// Ports:
//   i_clk   : rising-edge clock
//   i_reset : synchronous active-high reset
//   wb      : reg_writeback_if.slave (ALU/load inputs, read addresses, write/hazard outputs)
// Optional macro WB_BYPASS_EN: drives byp*_valid/byp*_data from the output stage and
// suppresses the hazard that stage alone would raise.
module reg_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 16
) (
    input logic            i_clk,
    input logic            i_reset,
    reg_writeback_if.slave wb
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] r_dest   [DEPTH];
    logic [DW-1:0] r_data   [DEPTH];
    logic          r_fwr0   [DEPTH];
    logic [DW-1:0] r_r0data [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;

    logic          r_regwrite, r_r0write;
    logic [AW-1:0] r_wadd;
    logic [DW-1:0] r_wdata, r_wr0;

    logic w_push, w_pop;
    logic w_fm1, w_fm2, w_r0p;
    logic w_out1, w_out2, w_r0h1, w_r0h2;

    assign wb.alu_ready = (r_count != CW'(DEPTH));
    assign wb.count     = r_count;
    assign wb.regwrite  = r_regwrite;
    assign wb.wadd      = r_wadd;
    assign wb.wdata     = r_wdata;
    assign wb.r0write   = r_r0write;
    assign wb.wr0       = r_wr0;

    assign w_push = wb.alu_valid && wb.alu_ready;
    // Loads have no backpressure, so the FIFO only drains in cycles without a load.
    assign w_pop  = !wb.mem_valid && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_dest[r_wptr]   <= wb.alu_dest;
            r_data[r_wptr]   <= wb.alu_data;
            r_fwr0[r_wptr]   <= wb.alu_wr0;
            r_r0data[r_wptr] <= wb.alu_r0data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_regwrite <= 1'b0;
            r_r0write  <= 1'b0;
            r_wadd     <= '0;
            r_wdata    <= '0;
            r_wr0      <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (wb.mem_valid) begin
                r_regwrite <= 1'b1;
                r_wadd     <= wb.mem_dest;
                r_wdata    <= wb.mem_data;
                r_r0write  <= 1'b0;
            end else if (w_pop) begin
                r_regwrite <= 1'b1;
                r_wadd     <= r_dest[r_rptr];
                r_wdata    <= r_data[r_rptr];
                r_r0write  <= r_fwr0[r_rptr];
                if (r_fwr0[r_rptr]) r_wr0 <= r_r0data[r_rptr];
            end else begin
                r_regwrite <= 1'b0;
                r_r0write  <= 1'b0;
            end
        end
    end

    // Scan occupied FIFO slots: slot i is live when its distance from the read pointer
    // is below the occupancy.
    always_comb begin
        logic [PW-1:0] off;
        w_fm1 = 1'b0;
        w_fm2 = 1'b0;
        w_r0p = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off = PW'(i) - r_rptr;
            if ({1'b0, off} < r_count) begin
                if (r_dest[i] == wb.add1) w_fm1 = 1'b1;
                if (r_dest[i] == wb.add2) w_fm2 = 1'b1;
                if (r_fwr0[i])            w_r0p = 1'b1;
            end
        end
    end

    assign w_out1 = r_regwrite && (r_wadd == wb.add1);
    assign w_out2 = r_regwrite && (r_wadd == wb.add2);
    assign w_r0h1 = (wb.add1 == '0) && (w_r0p || r_r0write);
    assign w_r0h2 = (wb.add2 == '0) && (w_r0p || r_r0write);

`ifdef WB_BYPASS_EN
    // Bypass only when the output stage holds the youngest pending value for the address.
    assign wb.byp1_valid = w_out1 && !w_fm1 && !w_r0h1;
    assign wb.byp2_valid = w_out2 && !w_fm2 && !w_r0h2;
    assign wb.byp1_data  = r_wdata;
    assign wb.byp2_data  = r_wdata;
    assign wb.hazard1    = w_fm1 || w_r0h1 || (w_out1 && !wb.byp1_valid);
    assign wb.hazard2    = w_fm2 || w_r0h2 || (w_out2 && !wb.byp2_valid);
`else
    assign wb.hazard1    = w_fm1 || w_out1 || w_r0h1;
    assign wb.hazard2    = w_fm2 || w_out2 || w_r0h2;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed vector table, hand-written fill/reset sequences and random
// traffic, all checked against a queue-based reference model of the write-back rules.
module tb_reg_writeback;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic        rst;
        logic        av;
        logic [3:0]  ad;
        logic [15:0] adata;
        logic        aw0;
        logic [15:0] ar0;
        logic        mv;
        logic [3:0]  md;
        logic [15:0] mdata;
        logic [3:0]  a1;
        logic [3:0]  a2;
    } in_t;

    typedef struct {
        in_t         i;
        logic        rw;
        logic [3:0]  wadd;
        logic [15:0] wdata;
        logic        r0w;
        logic [15:0] wr0;
        logic [2:0]  cnt;
        logic        h1;
        logic        h2;
        logic        rdy;
    } vec_t;

    typedef struct {
        logic [3:0]  dest;
        logic [15:0] data;
        logic        wr0;
        logic [15:0] r0data;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_writeback_if #(.DEPTH(DEPTH), .AW(4), .DW(16)) bus ();

    reg_writeback #(.DEPTH(DEPTH), .AW(4), .DW(16)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .wb      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    ent_t        m_q[$];
    logic        m_known = 1'b0;
    logic        m_rw, m_r0w;
    logic [3:0]  m_wadd;
    logic [15:0] m_wdata, m_wr0;
    in_t         cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic m_haz(input logic [3:0] a);
        logic h = 1'b0;
        foreach (m_q[k]) if (m_q[k].dest == a || (a == 4'd0 && m_q[k].wr0)) h = 1'b1;
        if (m_rw && m_wadd == a) h = 1'b1;
        if (a == 4'd0 && m_r0w) h = 1'b1;
        return h;
    endfunction

    function automatic in_t idle(input logic [3:0] a1, input logic [3:0] a2);
        in_t t = '{1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 16'd0, 1'b0, 4'd0, 16'd0, a1, a2};
        return t;
    endfunction

    // Apply inputs mid-cycle and compare every output against the model.
    task automatic drive(input in_t t);
        @(negedge clk);
        cur = t;
        reset = t.rst;
        bus.alu_valid = t.av;  bus.alu_dest = t.ad;  bus.alu_data = t.adata;
        bus.alu_wr0 = t.aw0;   bus.alu_r0data = t.ar0;
        bus.mem_valid = t.mv;  bus.mem_dest = t.md;  bus.mem_data = t.mdata;
        bus.add1 = t.a1;       bus.add2 = t.a2;
        #1;
        if (m_known) begin
            chk("regwrite", 32'(bus.regwrite), 32'(m_rw));
            chk("r0write", 32'(bus.r0write), 32'(m_r0w));
            chk("wr0", 32'(bus.wr0), 32'(m_wr0));
            chk("count", 32'(bus.count), 32'(m_q.size()));
            chk("alu_ready", 32'(bus.alu_ready), 32'(m_q.size() < DEPTH));
            chk("hazard1", 32'(bus.hazard1), 32'(m_haz(t.a1)));
            chk("hazard2", 32'(bus.hazard2), 32'(m_haz(t.a2)));
            if (m_rw) begin
                chk("wadd", 32'(bus.wadd), 32'(m_wadd));
                chk("wdata", 32'(bus.wdata), 32'(m_wdata));
            end
        end
    endtask

    // Advance one clock edge and apply the write-back rules to the model.
    task automatic tick();
        ent_t e;
        logic can_push;
        @(posedge clk);
        if (cur.rst) begin
            m_q.delete();
            m_rw = 1'b0; m_r0w = 1'b0; m_wadd = '0; m_wdata = '0; m_wr0 = '0;
            m_known = 1'b1;
        end else begin
            can_push = (m_q.size() < DEPTH);
            if (cur.mv) begin
                m_rw = 1'b1; m_wadd = cur.md; m_wdata = cur.mdata; m_r0w = 1'b0;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_rw = 1'b1; m_wadd = e.dest; m_wdata = e.data; m_r0w = e.wr0;
                if (e.wr0) m_wr0 = e.r0data;
            end else begin
                m_rw = 1'b0; m_r0w = 1'b0;
            end
            if (cur.av && can_push) m_q.push_back('{cur.ad, cur.adata, cur.aw0, cur.ar0});
        end
    endtask

    vec_t tbl[12];
    in_t  t;

    initial begin
        // Single ALU result, load priority, then R0 dual write; starts from reset state.
        tbl[0]  = '{'{1'b0,1'b1,4'd3,16'h1234,1'b0,16'h0,1'b0,4'd0,16'h0,4'd3,4'd0},
                   1'b0,4'd0,16'h0,1'b0,16'h0,3'd0,1'b0,1'b0,1'b1};
        tbl[1]  = '{idle(4'd3,4'd0), 1'b0,4'd0,16'h0,1'b0,16'h0,3'd1,1'b1,1'b0,1'b1};
        tbl[2]  = '{idle(4'd3,4'd0), 1'b1,4'd3,16'h1234,1'b0,16'h0,3'd0,1'b1,1'b0,1'b1};
        tbl[3]  = '{idle(4'd3,4'd0), 1'b0,4'd0,16'h0,1'b0,16'h0,3'd0,1'b0,1'b0,1'b1};
        tbl[4]  = '{'{1'b0,1'b1,4'd5,16'h5555,1'b0,16'h0,1'b0,4'd0,16'h0,4'd5,4'd7},
                   1'b0,4'd0,16'h0,1'b0,16'h0,3'd0,1'b0,1'b0,1'b1};
        tbl[5]  = '{'{1'b0,1'b0,4'd0,16'h0,1'b0,16'h0,1'b1,4'd7,16'hBEEF,4'd5,4'd7},
                   1'b0,4'd0,16'h0,1'b0,16'h0,3'd1,1'b1,1'b0,1'b1};
        tbl[6]  = '{idle(4'd5,4'd7), 1'b1,4'd7,16'hBEEF,1'b0,16'h0,3'd1,1'b1,1'b1,1'b1};
        tbl[7]  = '{idle(4'd5,4'd7), 1'b1,4'd5,16'h5555,1'b0,16'h0,3'd0,1'b1,1'b0,1'b1};
        tbl[8]  = '{'{1'b0,1'b1,4'd2,16'h0010,1'b1,16'h0003,1'b0,4'd0,16'h0,4'd2,4'd0},
                   1'b0,4'd0,16'h0,1'b0,16'h0,3'd0,1'b0,1'b0,1'b1};
        tbl[9]  = '{idle(4'd2,4'd0), 1'b0,4'd0,16'h0,1'b0,16'h0,3'd1,1'b1,1'b1,1'b1};
        tbl[10] = '{idle(4'd2,4'd0), 1'b1,4'd2,16'h0010,1'b1,16'h0003,3'd0,1'b1,1'b1,1'b1};
        tbl[11] = '{idle(4'd2,4'd0), 1'b0,4'd0,16'h0,1'b0,16'h0003,3'd0,1'b0,1'b0,1'b1};

        t = idle(4'd0, 4'd0);
        t.rst = 1'b1;
        drive(t); tick();

        foreach (tbl[r]) begin
            drive(tbl[r].i);
            chk($sformatf("tbl%0d.regwrite", r), 32'(bus.regwrite), 32'(tbl[r].rw));
            if (tbl[r].rw) begin
                chk($sformatf("tbl%0d.wadd", r), 32'(bus.wadd), 32'(tbl[r].wadd));
                chk($sformatf("tbl%0d.wdata", r), 32'(bus.wdata), 32'(tbl[r].wdata));
            end
            chk($sformatf("tbl%0d.r0write", r), 32'(bus.r0write), 32'(tbl[r].r0w));
            chk($sformatf("tbl%0d.wr0", r), 32'(bus.wr0), 32'(tbl[r].wr0));
            chk($sformatf("tbl%0d.count", r), 32'(bus.count), 32'(tbl[r].cnt));
            chk($sformatf("tbl%0d.hazard1", r), 32'(bus.hazard1), 32'(tbl[r].h1));
            chk($sformatf("tbl%0d.hazard2", r), 32'(bus.hazard2), 32'(tbl[r].h2));
            chk($sformatf("tbl%0d.alu_ready", r), 32'(bus.alu_ready), 32'(tbl[r].rdy));
            tick();
        end

        // Fill to full while loads block every pop; the 5th offer waits for a pop.
        for (int k = 0; k < 4; k++) begin
            t = idle(4'd8, 4'd1);
            t.av = 1'b1; t.ad = 4'(8 + k); t.adata = 16'($urandom);
            t.mv = 1'b1; t.md = 4'd1; t.mdata = 16'($urandom);
            drive(t); tick();
        end
        t.ad = 4'd12; t.adata = 16'hC0DE;
        drive(t);
        chk("full.count", 32'(bus.count), 32'd4);
        chk("full.ready", 32'(bus.alu_ready), 32'd0);
        tick();
        t.mv = 1'b0;
        drive(t);
        chk("full.hold_count", 32'(bus.count), 32'd4);
        chk("full.pop_ready", 32'(bus.alu_ready), 32'd0);
        tick();
        drive(t);
        chk("full.after_pop_count", 32'(bus.count), 32'd3);
        chk("full.after_pop_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        drive(idle(4'd12, 4'd0));
        chk("full.fifth_taken", 32'(bus.count), 32'd3);
        chk("full.fifth_hazard", 32'(bus.hazard1), 32'd1);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(idle(4'd12, 4'd0)); tick();
        end

        // Reset with three queued entries and a load in flight.
        for (int k = 0; k < 3; k++) begin
            t = idle(4'd4, 4'd0);
            t.av = 1'b1; t.ad = 4'd4; t.adata = 16'(k); t.mv = 1'b1; t.md = 4'd6;
            drive(t); tick();
        end
        t.rst = 1'b1;
        drive(t);
        chk("midrst.count_before", 32'(bus.count), 32'd3);
        tick();
        drive(idle(4'd4, 4'd6));
        chk("midrst.regwrite", 32'(bus.regwrite), 32'd0);
        chk("midrst.count", 32'(bus.count), 32'd0);
        chk("midrst.ready", 32'(bus.alu_ready), 32'd1);
        chk("midrst.hazard1", 32'(bus.hazard1), 32'd0);
        tick();
        drive(idle(4'd4, 4'd6));
        chk("midrst.regwrite2", 32'(bus.regwrite), 32'd0);
        tick();

        // Random traffic with a narrow address range to exercise hazards.
        for (int n = 0; n < 3000; n++) begin
            t.rst   = ($urandom_range(0, 149) == 0);
            t.av    = ($urandom_range(0, 1) == 1);
            t.ad    = 4'($urandom_range(0, 3));
            t.adata = 16'($urandom);
            t.aw0   = ($urandom_range(0, 3) == 0);
            t.ar0   = 16'($urandom);
            t.mv    = ($urandom_range(0, 3) == 0);
            t.md    = 4'($urandom_range(0, 3));
            t.mdata = 16'($urandom);
            t.a1    = 4'($urandom_range(0, 4));
            t.a2    = 4'($urandom_range(0, 4));
            drive(t); tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
Write-side companion to the 16-entry x 16-bit register file. Accepts results from the ALU and from the memory load path, and buffers ALU results in a 4-entry FIFO. Each cycle it issues at most one general-register write (wadd/wdata/regwrite) plus an optional R0 write (wr0/r0write) into the register file. It also reports read-after-write hazards for the two register-file read addresses, so operand fetch can stall.

Parameters:
DEPTH, 4, ALU result FIFO entries (power of 2, 2..16)
AW, 4, register address width
DW, 16, data width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU result offered
alu_ready  output  1  FIFO can accept (not full)
alu_dest  input  AW  destination register
alu_data  input  DW  result for alu_dest
alu_wr0  input  1  result also writes R0 (mul high / div remainder)
alu_r0data  input  DW  value for R0 when alu_wr0=1
mem_valid  input  1  load data returning this cycle; no backpressure
mem_dest  input  AW  load destination
mem_data  input  DW  load data
add1  input  AW  register-file read address 1
add2  input  AW  register-file read address 2
hazard1  output  1  add1 has a pending write
hazard2  output  1  add2 has a pending write
wadd  output  AW  write address to register file
wdata  output  DW  write data
regwrite  output  1  general write strobe
wr0  output  DW  R0 write data
r0write  output  1  R0 write strobe
count  output  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (clk edge with reset=1): FIFO empty, count=0, regwrite=0, r0write=0, wadd=0, wdata=0, wr0=0. alu_ready=1 in the following cycle. Reset mid-stream discards all queued entries and any in-flight mem_valid in the same cycle.
- ALU accept: push when alu_valid && alu_ready at the clk edge. The entry is {alu_dest, alu_data, alu_wr0, alu_r0data}. alu_ready = (count != DEPTH), combinational from registered count.
- Write outputs are registered with 1-cycle latency: a write decided in cycle N appears on wadd/wdata/regwrite in cycle N+1, for exactly one cycle.
- Arbitration per cycle:
  - mem_valid=1: the load wins. Issue regwrite with mem_dest/mem_data, r0write=0. FIFO does not pop.
  - else if FIFO not empty: pop the head. Issue regwrite with its dest/data. If the head's alu_wr0=1, also issue r0write=1 with wr0=alu_r0data in the same cycle.
  - else: regwrite=0, r0write=0. wadd/wdata/wr0 hold their last values.
- Simultaneous push and pop: count unchanged. A push into an empty FIFO cannot pop in the same cycle; minimum ALU-to-regwrite latency is 2 cycles.
- Full FIFO: alu_ready=0 and an offered alu_valid is not taken. A pop in the same cycle does not raise alu_ready until the next cycle.
- Pointers wrap modulo DEPTH. count saturates by construction (no push when full, no pop when empty).
- Destination address 0 is a legal general write. R0 writes through r0write are independent of wadd.
- Hazards (combinational):
  - hazardN=1 if addN matches the dest of any valid FIFO entry, or the dest of a write registered this cycle (regwrite=1 && wadd==addN).
  - hazardN=1 if addN==0 and any valid FIFO entry has alu_wr0=1, or r0write=1.

Optional Feature:
WB_BYPASS_EN.
- Defined: adds outputs byp1_valid, byp1_data, byp2_valid, byp2_data. When the youngest pending write to addN is the registered output stage (wadd==addN, regwrite=1), bypN_valid=1 and bypN_data=wdata. hazardN is then suppressed for that address only if no younger FIFO entry targets it.
- Undefined: no bypass ports; hazards as above.

Test Plan:
- Reset: reset=1 for 1 cycle -> count=0, regwrite=0, r0write=0, alu_ready=1, hazard1=hazard2=0.
- Single ALU result: alu_valid for 1 cycle with dest=3, data=16'h1234 -> 2 cycles later regwrite=1, wadd=3, wdata=16'h1234 for one cycle; hazard1=1 with add1=3 until after that cycle.
- Fill to full: 5 back-to-back alu_valid with no pops (mem_valid=1 every cycle) -> alu_ready=0 after 4 accepted, count=4. The 5th is accepted only after mem_valid drops and one pop.
- Load priority: FIFO holds dest=5; mem_valid with dest=7, data=16'hBEEF in the same cycle -> first write is wadd=7/16'hBEEF, next is wadd=5.
- R0 dual write: alu_wr0=1, dest=2, data=16'h0010, r0data=16'h0003 -> regwrite and r0write in the same cycle, wr0=16'h0003. hazard with add2=0 is 1 before the write.
- Reset mid-operation: 3 entries queued, reset=1 -> no further regwrite, count=0 the next cycle.
